enc8b10b_lanes: RTL and testbench

//  Parametrised multi-lane 8b/10b encoder: accepts LANES bytes + K flags per beat and emits LANES 10-bit symbols.
//  Per-lane 5b/6b + 3b/4b mapping, including the alternate D.x.A7 encoding.

---
 rtl/enc8b10b_pkg.sv | 49 ++++
 rtl/enc8b10b_lane.sv | 105 ++++++++++
 rtl/enc8b10b_lanes.sv | 69 ++++++
 tb/tb_enc8b10b_lanes.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc8b10b_pkg.sv
// Shared widths, K-code constants and disparity helpers for the 8b/10b lane encoder.
// ENC8B10B_KERR_EN (optional) enables illegal control-code detection in the lanes.
package enc8b10b_pkg;

    localparam int SYM_W  = 10;
    localparam int BYTE_W = 8;

    localparam logic [SYM_W-1:0] K28_5_RDN = 10'h0FA;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'h305;

    localparam int NUM_LEGAL_K = 12;
    localparam logic [BYTE_W-1:0] LEGAL_K [NUM_LEGAL_K] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    typedef enum logic [1:0] {
        DISP_ZERO,
        DISP_POS,
        DISP_NEG
    } disp_e;

    function automatic disp_e disp6(input logic [5:0] c);
        int ones;
        ones = 0;
        for (int i = 0; i < 6; i++) ones += int'(c[i]);
        if (ones > 3)      return DISP_POS;
        else if (ones < 3) return DISP_NEG;
        else               return DISP_ZERO;
    endfunction

    function automatic disp_e disp4(input logic [3:0] c);
        int ones;
        ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(c[i]);
        if (ones > 2)      return DISP_POS;
        else if (ones < 2) return DISP_NEG;
        else               return DISP_ZERO;
    endfunction

    function automatic logic is_legal_k(input logic [BYTE_W-1:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LEGAL_K; i++)
            if (LEGAL_K[i] == b) hit = 1'b1;
        return hit;
    endfunction

endpackage

// File: rtl/enc8b10b_lane.sv
// Combinational single-byte 8b/10b encoder: 5b/6b then 3b/4b, RD in -> RD out.
// With ENC8B10B_KERR_EN an illegal K byte is flagged and encoded as data.
module enc8b10b_lane
    import enc8b10b_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    input  logic              k,
    input  logic              rd_in,
    output logic [SYM_W-1:0]  sym,
    output logic              rd_out,
    output logic              kerr
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k_eff;
    logic [5:0] c6n;
    logic [5:0] c6;
    logic [3:0] c4n;
    logic [3:0] c4;
    logic       rd6;
    logic       alt;

    assign x = data[4:0];
    assign y = data[7:5];

`ifdef ENC8B10B_KERR_EN
    assign kerr  = k & ~is_legal_k(data);
    assign k_eff = k & ~kerr;
`else
    assign kerr  = 1'b0;
    assign k_eff = k;
`endif

    // RD- column; the RD+ column is its complement for unbalanced codes and D.07
    function automatic logic [5:0] code6(input logic [4:0] v);
        case (v)
            5'd0:  return 6'b100111;
            5'd1:  return 6'b011101;
            5'd2:  return 6'b101101;
            5'd3:  return 6'b110001;
            5'd4:  return 6'b110101;
            5'd5:  return 6'b101001;
            5'd6:  return 6'b011001;
            5'd7:  return 6'b111000;
            5'd8:  return 6'b111001;
            5'd9:  return 6'b100101;
            5'd10: return 6'b010101;
            5'd11: return 6'b110100;
            5'd12: return 6'b001101;
            5'd13: return 6'b101100;
            5'd14: return 6'b011100;
            5'd15: return 6'b010111;
            5'd16: return 6'b011011;
            5'd17: return 6'b100011;
            5'd18: return 6'b010011;
            5'd19: return 6'b110010;
            5'd20: return 6'b001011;
            5'd21: return 6'b101010;
            5'd22: return 6'b011010;
            5'd23: return 6'b111010;
            5'd24: return 6'b110011;
            5'd25: return 6'b100110;
            5'd26: return 6'b010110;
            5'd27: return 6'b110110;
            5'd28: return 6'b001110;
            5'd29: return 6'b101110;
            5'd30: return 6'b011110;
            default: return 6'b101011;
        endcase
    endfunction

    always_comb begin
        c6n = code6(x);
        if (k_eff && x == 5'd28)
            c6 = rd_in ? K28_5_RDP[9:4] : K28_5_RDN[9:4];
        else if (rd_in && (disp6(c6n) != DISP_ZERO || x == 5'd7))
            c6 = ~c6n;
        else
            c6 = c6n;
        rd6 = rd_in ^ (disp6(c6) != DISP_ZERO);

        alt = k_eff | (rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                           : (x == 5'd17 || x == 5'd18 || x == 5'd20));
        case (y)
            3'd0:    c4n = 4'b1011;
            3'd1:    c4n = k_eff ? 4'b0110 : 4'b1001;
            3'd2:    c4n = k_eff ? 4'b1010 : 4'b0101;
            3'd3:    c4n = 4'b1100;
            3'd4:    c4n = 4'b1101;
            3'd5:    c4n = k_eff ? 4'b0101 : 4'b1010;
            3'd6:    c4n = k_eff ? 4'b1001 : 4'b0110;
            default: c4n = alt ? 4'b0111 : 4'b1110;
        endcase
        // every K column entry flips at RD+, as do D.x.3 and unbalanced codes
        if (rd6 && (k_eff || y == 3'd3 || disp4(c4n) != DISP_ZERO))
            c4 = ~c4n;
        else
            c4 = c4n;
        rd_out = rd6 ^ (disp4(c4) != DISP_ZERO);
    end

    assign sym = {c6, c4};

endmodule

// File: rtl/enc8b10b_lanes.sv
// Multi-lane 8b/10b encoder with RD chained across lanes and beats, one registered stage.
// Optional ENC8B10B_KERR_EN flags illegal control codes on out_kerr.
module enc8b10b_lanes
    import enc8b10b_pkg::*;
#(
    parameter int LANES    = 4,
    parameter bit RD_RESET = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W*LANES-1:0] in_data,
    input  logic [LANES-1:0]        in_k,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SYM_W*LANES-1:0]  out_data,
    output logic                    out_rd,
    output logic [LANES-1:0]        out_kerr
);

    logic                        rd_q;
    logic [LANES:0]              rd_chain;
    logic [LANES-1:0][SYM_W-1:0] sym;
    logic [LANES-1:0]            kerr;
    logic                        xfer;

    assign in_ready    = ~out_valid | out_ready;
    assign xfer        = in_valid & in_ready;
    assign rd_chain[0] = rd_q;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        enc8b10b_lane u_lane (
            .data   (in_data[BYTE_W*n +: BYTE_W]),
            .k      (in_k[n]),
            .rd_in  (rd_chain[n]),
            .sym    (sym[n]),
            .rd_out (rd_chain[n+1]),
            .kerr   (kerr[n])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_kerr  <= '0;
            out_rd    <= RD_RESET;
            rd_q      <= RD_RESET;
        end else begin
            if (xfer) begin
                out_data <= sym;
                out_kerr <= kerr;
                out_rd   <= rd_clr ? RD_RESET : rd_chain[LANES];
            end
            if (xfer)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            // rd_clr wins, but this beat's symbols already used the old RD
            if (rd_clr)
                rd_q <= RD_RESET;
            else if (xfer)
                rd_q <= rd_chain[LANES];
        end
    end

endmodule

// File: tb/tb_enc8b10b_lanes.sv
// Self-checking bench for enc8b10b_lanes: table-driven reference encoder, per-cycle compare,
// directed literal beats and randomized traffic.
module tb_enc8b10b_lanes;

    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_k = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_rd;
    logic [39:0] out_data;
    logic [3:0]  out_kerr;

    int checks = 0;
    int errors = 0;

    enc8b10b_lanes #(.LANES(LANES), .RD_RESET(1'b0)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .rd_clr    (rd_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_kerr  (out_kerr)
    );

    always #5 clk = ~clk;

    // Standard code tables, both disparity columns written out explicitly
    logic [5:0] t6n [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] t6p [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] t4dn [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] t4dp [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    logic [3:0] t4kn [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    logic [3:0] t4kp [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    logic [7:0] legal_k [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    // returns {kerr, rd_after, 10-bit symbol}
    function automatic logic [11:0] enc(input logic [7:0] d, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       ke;
        logic       ker;
        logic       r;
        logic       alt;
        logic [5:0] s6;
        logic [3:0] s4;
        x = d[4:0];
        y = d[7:5];
`ifdef ENC8B10B_KERR_EN
        begin
            logic legal;
            legal = 1'b0;
            for (int i = 0; i < 12; i++) if (legal_k[i] == d) legal = 1'b1;
            ker = k && !legal;
            ke  = k && legal;
        end
`else
        ker = 1'b0;
        ke  = k;
`endif
        r = rd;
        alt = 1'b0;
        if (ke && x == 5'd28) s6 = rd ? 6'b110000 : 6'b001111;
        else                  s6 = rd ? t6p[x] : t6n[x];
        if ($countones(s6) != 3) r = !r;
        if (ke) s4 = r ? t4kp[y] : t4kn[y];
        else if (y == 3'd7) begin
            alt = r ? (x == 5'd11 || x == 5'd13 || x == 5'd14) : (x == 5'd17 || x == 5'd18 || x == 5'd20);
            s4 = r ? (alt ? 4'b1000 : 4'b0001) : (alt ? 4'b0111 : 4'b1110);
        end else s4 = r ? t4dp[y] : t4dn[y];
        if ($countones(s4) != 2) r = !r;
        return {ker, r, s6, s4};
    endfunction

    // returns {kerr[3:0], rd_after, lanes[39:0]}
    function automatic logic [44:0] enc_beat(input logic [31:0] d, input logic [3:0] k, input logic rd);
        logic        r;
        logic [39:0] s;
        logic [3:0]  ke;
        logic [11:0] e;
        r = rd;
        for (int n = 0; n < 4; n++) begin
            e = enc(d[8*n +: 8], k[n], r);
            s[10*n +: 10] = e[9:0];
            r = e[10];
            ke[n] = e[11];
        end
        return {ke, r, s};
    endfunction

    // reference state
    logic        m_valid;
    logic [39:0] m_data;
    logic        m_rd;
    logic [3:0]  m_kerr;
    logic        m_rdreg;
    logic [44:0] m_next;
    logic        m_xfer;

    assign m_next = enc_beat(in_data, in_k, m_rdreg);
    assign m_xfer = in_valid && (!m_valid || out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_rd    <= 1'b0;
            m_kerr  <= '0;
            m_rdreg <= 1'b0;
        end else begin
            if (m_xfer) begin
                m_data  <= m_next[39:0];
                m_kerr  <= m_next[44:41];
                m_rd    <= rd_clr ? 1'b0 : m_next[40];
                m_valid <= 1'b1;
            end else if (out_ready) m_valid <= 1'b0;
            if (rd_clr)      m_rdreg <= 1'b0;
            else if (m_xfer) m_rdreg <= m_next[40];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("valid", out_valid, m_valid);
        chk("ready", in_ready, !m_valid || out_ready);
        chk("data", out_data, m_data);
        chk("rd", out_rd, m_rd);
        chk("kerr", out_kerr, m_kerr);
    end

    function automatic logic [9:0] lane(input int n);
        return out_data[10*n +: 10];
    endfunction

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic clr);
        int t;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_k = k; rd_clr = clr;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck low for %0d cycles", t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rd_clr = 1'b0;
    endtask

    initial begin
        // pin the reference itself
        chk("model_d0_0_rdn", enc(8'h00, 1'b0, 1'b0), 12'h274);
        chk("model_k28_5_rdn", enc(8'hBC, 1'b1, 1'b0), 12'h4FA);
        chk("model_k28_5_rdp", enc(8'hBC, 1'b1, 1'b1), 12'h305);
        chk("model_d21_5_rdn", enc(8'hB5, 1'b0, 1'b0), 12'h2AA);
        chk("model_d21_5_rdp", enc(8'hB5, 1'b0, 1'b1), 12'h6AA);
        chk("model_d17_7_rdn", enc(8'hF1, 1'b0, 1'b0), 12'h637);

        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_kerr", out_kerr, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        send(32'hBCBCBCBC, 4'hF, 1'b0);
        chk("k285x4_l0", lane(0), 10'h0FA);
        chk("k285x4_l1", lane(1), 10'h305);
        chk("k285x4_l2", lane(2), 10'h0FA);
        chk("k285x4_l3", lane(3), 10'h305);
        chk("k285x4_rd", out_rd, 0);

        send(32'h00000000, 4'h0, 1'b0);
        chk("d0_0_l0", lane(0), 10'h274);
        chk("d0_0_rd", out_rd, 0);

        send(32'h000000BC, 4'h1, 1'b0);
        chk("k_then_d_l0", lane(0), 10'h0FA);
        chk("k_then_d_l1", lane(1), 10'h18B);
        chk("k_then_d_rd", out_rd, 1);
        send(32'h000000BC, 4'h1, 1'b0);
        chk("k285_rdp_l0", lane(0), 10'h305);
        chk("k285_rdp_l1", lane(1), 10'h274);
        chk("k285_rdp_rd", out_rd, 0);

        send(32'hB5B5B5B5, 4'h0, 1'b0);
        chk("d21_5_rdn_l0", lane(0), 10'h2AA);
        chk("d21_5_rdn_rd", out_rd, 0);
        send(32'hB5B5B5BC, 4'h1, 1'b0);
        chk("k_d21_5_l1", lane(1), 10'h2AA);
        chk("k_d21_5_rd", out_rd, 1);
        send(32'hB5B5B5B5, 4'h0, 1'b0);
        chk("d21_5_rdp_l0", lane(0), 10'h2AA);
        chk("d21_5_rdp_rd", out_rd, 1);
        send(32'hB5B5F1BC, 4'h1, 1'b0);
        chk("d17_7_l0", lane(0), 10'h305);
        chk("d17_7_l1", lane(1), 10'h237);
        chk("d17_7_rd", out_rd, 1);

        // backpressure with a pending beat
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hB5B5B5BC; in_k = 4'h1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("bp_ready", in_ready, 0);
            chk("bp_hold_l1", lane(1), 10'h237);
            chk("bp_hold_rd", out_rd, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_rel_l0", lane(0), 10'h305);
        chk("bp_rel_rd", out_rd, 0);
        @(posedge clk); #1;
        chk("bp_drain_valid", out_valid, 0);
        send(32'h000000BC, 4'h1, 1'b0);
        chk("bp_rd_once", lane(0), 10'h0FA);

        send(32'hB5B5B5B5, 4'h0, 1'b1);
        chk("rdclr_sym", lane(0), 10'h2AA);
        chk("rdclr_rd", out_rd, 0);
        send(32'h000000BC, 4'h1, 1'b0);
        chk("rdclr_next", lane(0), 10'h0FA);
        send(32'h000000BC, 4'h1, 1'b0);

        send(32'h00000000, 4'h1, 1'b0);
        chk("kerr_sym", lane(0), 10'h274);
`ifdef ENC8B10B_KERR_EN
        chk("kerr_flag", out_kerr, 4'h1);
`else
        chk("kerr_flag", out_kerr, 4'h0);
`endif

        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            rd_clr    = ($urandom % 16) == 0;
            in_k      = 4'($urandom);
            for (int n = 0; n < 4; n++)
                in_data[8*n +: 8] = (in_k[n] && ($urandom % 2)) ? legal_k[$urandom % 12] : 8'($urandom);
        end

        // reset with a beat pending
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b0; rd_clr = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        send(32'hBCBCBCBC, 4'hF, 1'b0);
        chk("post_rst_l0", lane(0), 10'h0FA);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
